ascon_aead: RTL and testbench

Serial-in/serial-out Ascon AEAD encryption core (Ascon v1.2 family: Ascon-128 / Ascon-128a). Key, nonce, associated data and plaintext are shifted in one bit per clock. On a start pulse the core runs the full Ascon permutation-based encryption, one round per clock. It then shifts ciphertext and tag out one bit per clock. It sits behind a narrow pin-limited test/IO wrapper.

---
 rtl/ascon_aead.sv | 246 ++++++++++++++++++++++++
 tb/tb_ascon_aead.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_aead.sv
// Bit-serial Ascon-128 / Ascon-128a (v1.2) encryption core: serial load,
// one permutation round per clock, serial ciphertext and tag readout.
module ascon_aead #(
   parameter int k  = 128,
   parameter int r  = 64,
   parameter int a  = 12,
   parameter int b  = 6,
   parameter int l  = 40,
   parameter int y  = 40,
   parameter int TI = 1,
   parameter int FP = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] keyxSI,
   input  logic [2:0] noncexSI,
   input  logic [2:0] associated_dataxSI,
   input  logic [2:0] plain_textxSI,
   input  logic       encryption_startxSI,
   input  logic [6:0] r_64xSI,
   input  logic       r_128xSI,
   input  logic       r_ptxSI,
   output logic       cipher_textxSO,
   output logic       tagxSO,
   output logic       encryption_readyxSO
);

   localparam int M0  = (k > 128) ? k : 128;
   localparam int M1  = (M0 > l) ? M0 : l;
   localparam int M   = (M1 > y) ? M1 : y;
   localparam int NA  = (l > 0) ? (l / r + 1) : 0;
   localparam int NP  = y / r + 1;
   localparam int ADW = (l / r + 1) * r;
   localparam int PTW = NP * r;
   localparam int CW  = $clog2(M + 2);
   localparam logic [63:0]    IV      = {8'(k), 8'(r), 8'(a), 8'(b), 32'h0000_0000};
   localparam logic [ADW-1:0] AD_PAD  = {{(ADW-1){1'b0}}, 1'b1} << (ADW - 1 - l);
   localparam logic [PTW-1:0] PT_PAD  = {{(PTW-1){1'b0}}, 1'b1} << (PTW - 1 - y);
   localparam logic [3:0]     A_START = 4'(12 - a);
   localparam logic [3:0]     B_START = 4'(12 - b);

   typedef enum logic [3:0] {
      IDLE, SETUP, INIT, AD_ABS, AD_PERM, DOMAIN,
      PT_ABS, PT_PERM, FINAL_KEY, FINAL_PERM, TAG, DONE
   } state_e;

   function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
      return (x >> n) | (x << (64 - n));
   endfunction

   // One Ascon round: constant addition, bit-sliced S-box, linear diffusion.
   function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [7:0] c);
      logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
      x0 = s[319:256];
      x1 = s[255:192];
      x2 = s[191:128] ^ {56'h0, c};
      x3 = s[127:64];
      x4 = s[63:0];
      x0 = x0 ^ x4;  x4 = x4 ^ x3;  x2 = x2 ^ x1;
      t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
      x0 = x0 ^ t1;  x1 = x1 ^ t2;  x2 = x2 ^ t3;  x3 = x3 ^ t4;  x4 = x4 ^ t0;
      x1 = x1 ^ x0;  x0 = x0 ^ x4;  x3 = x3 ^ x2;  x2 = ~x2;
      x0 = x0 ^ rotr(x0, 19) ^ rotr(x0, 28);
      x1 = x1 ^ rotr(x1, 61) ^ rotr(x1, 39);
      x2 = x2 ^ rotr(x2, 1)  ^ rotr(x2, 6);
      x3 = x3 ^ rotr(x3, 10) ^ rotr(x3, 17);
      x4 = x4 ^ rotr(x4, 7)  ^ rotr(x4, 41);
      return {x0, x1, x2, x3, x4};
   endfunction

   state_e           state_q;
   logic [k-1:0]     key_q;
   logic [127:0]     nonce_q;
   logic [ADW-1:0]   ad_q;
   logic [PTW-1:0]   pt_q;
   logic [319:0]     s_q;
   logic [127:0]     tag_q;
   logic [CW-1:0]    ld_q, rd_q, blk_q;
   logic [3:0]       rnd_q;
   logic             ct_o_q, tag_o_q, rdy_q;

   logic [319:0]     round_d;
   logic [r-1:0]     ad_rate_d, pt_rate_d;
   logic [127:0]     tag_d, tag_src_s, tag_sh_s;
   logic [PTW-1:0]   ct_sh_s;
   logic [CW-1:0]    rd_d;
   logic [k-1:0]     key_mask_s;
   logic [127:0]     nonce_mask_s;
   logic [ADW-1:0]   ad_mask_s;
   logic [PTW-1:0]   pt_mask_s;
   logic             ct_bit_s, tag_bit_s, last_rnd_s;
   int               ld_i, rd_i, idx_i;
   logic             unused_s;

   assign unused_s = ^{keyxSI[2:1], noncexSI[2:1], associated_dataxSI[2:1], plain_textxSI[2:1],
                       r_64xSI, r_128xSI, r_ptxSI, (TI != 0), (FP != 0)};

   // Round datapath, absorb values, load masks and readout bit selection.
   always_comb begin
      round_d    = ascon_round(s_q, {4'hf - rnd_q, rnd_q});
      last_rnd_s = (rnd_q == 4'd11);
      ad_rate_d  = s_q[319 -: r] ^ ad_q[ADW-1 -: r];
      pt_rate_d  = s_q[319 -: r] ^ pt_q[PTW-1 -: r];
      tag_d      = s_q[127:0] ^ key_q;

      ld_i         = int'(ld_q);
      key_mask_s   = (ld_i < k)   ? ({{(k-1){1'b0}}, 1'b1} << (k - 1 - ld_i))     : {k{1'b0}};
      nonce_mask_s = (ld_i < 128) ? ({{127{1'b0}}, 1'b1} << (127 - ld_i))         : {128{1'b0}};
      ad_mask_s    = (ld_i < l)   ? ({{(ADW-1){1'b0}}, 1'b1} << (ADW - 1 - ld_i)) : {ADW{1'b0}};
      pt_mask_s    = (ld_i < y)   ? ({{(PTW-1){1'b0}}, 1'b1} << (PTW - 1 - ld_i)) : {PTW{1'b0}};

      // Readout index stays 0 for the first three ready cycles, then tracks rd - 2.
      rd_d  = (rd_q == CW'(M + 1)) ? rd_q : rd_q + CW'(1);
      rd_i  = int'(rd_d);
      if (state_q == DONE) begin
         idx_i     = (rd_i <= 2) ? 0 : rd_i - 2;
         tag_src_s = tag_q;
      end else begin
         idx_i     = 0;
         tag_src_s = tag_d;
      end
      ct_sh_s   = pt_q >> (PTW - y + idx_i);
      tag_sh_s  = tag_src_s >> idx_i;
      ct_bit_s  = (idx_i < y)   ? ct_sh_s[0]  : 1'b0;
      tag_bit_s = (idx_i < 128) ? tag_sh_s[0] : 1'b0;
   end

   // Control FSM with the load, permutation and readout registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         key_q   <= '0;
         nonce_q <= '0;
         ad_q    <= '0;
         pt_q    <= '0;
         s_q     <= '0;
         tag_q   <= '0;
         ld_q    <= '0;
         rd_q    <= '0;
         blk_q   <= '0;
         rnd_q   <= '0;
         ct_o_q  <= 1'b0;
         tag_o_q <= 1'b0;
         rdy_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (encryption_startxSI) begin
                  state_q <= SETUP;
               end else begin
                  key_q   <= (key_q & ~key_mask_s)     | (key_mask_s & {k{keyxSI[0]}});
                  nonce_q <= (nonce_q & ~nonce_mask_s) | (nonce_mask_s & {128{noncexSI[0]}});
                  ad_q    <= (ad_q & ~ad_mask_s)       | (ad_mask_s & {ADW{associated_dataxSI[0]}});
                  pt_q    <= (pt_q & ~pt_mask_s)       | (pt_mask_s & {PTW{plain_textxSI[0]}});
                  ld_q    <= (ld_q == CW'(M - 1)) ? ld_q : ld_q + CW'(1);
               end
            end
            SETUP: begin
               s_q     <= {IV, key_q, nonce_q};
               ad_q    <= ad_q | AD_PAD;
               pt_q    <= pt_q | PT_PAD;
               rnd_q   <= A_START;
               state_q <= INIT;
            end
            INIT: begin
               rnd_q <= rnd_q + 4'd1;
               blk_q <= '0;
               if (last_rnd_s) begin
                  s_q     <= round_d ^ {{(320-k){1'b0}}, key_q};
                  state_q <= (NA > 0) ? AD_ABS : DOMAIN;
               end else begin
                  s_q <= round_d;
               end
            end
            AD_ABS: begin
               s_q     <= {ad_rate_d, s_q[319-r:0]};
               ad_q    <= ad_q << r;
               blk_q   <= blk_q + CW'(1);
               rnd_q   <= B_START;
               state_q <= AD_PERM;
            end
            AD_PERM: begin
               s_q   <= round_d;
               rnd_q <= rnd_q + 4'd1;
               if (last_rnd_s) begin
                  state_q <= (blk_q == CW'(NA)) ? DOMAIN : AD_ABS;
               end
            end
            DOMAIN: begin
               s_q     <= s_q ^ {{319{1'b0}}, 1'b1};
               blk_q   <= '0;
               state_q <= PT_ABS;
            end
            PT_ABS: begin
               // Ciphertext blocks accumulate in the plaintext register, first block ending on top.
               s_q   <= {pt_rate_d, s_q[319-r:0]};
               pt_q  <= (pt_q << r) | PTW'(pt_rate_d);
               blk_q <= blk_q + CW'(1);
               rnd_q <= B_START;
               state_q <= (blk_q == CW'(NP - 1)) ? FINAL_KEY : PT_PERM;
            end
            PT_PERM: begin
               s_q   <= round_d;
               rnd_q <= rnd_q + 4'd1;
               if (last_rnd_s) begin
                  state_q <= PT_ABS;
               end
            end
            FINAL_KEY: begin
               s_q     <= s_q ^ ({key_q, {(320-k){1'b0}}} >> r);
               rnd_q   <= A_START;
               state_q <= FINAL_PERM;
            end
            FINAL_PERM: begin
               s_q   <= round_d;
               rnd_q <= rnd_q + 4'd1;
               if (last_rnd_s) begin
                  state_q <= TAG;
               end
            end
            TAG: begin
               tag_q   <= tag_d;
               rd_q    <= '0;
               ct_o_q  <= ct_bit_s;
               tag_o_q <= tag_bit_s;
               rdy_q   <= 1'b1;
               state_q <= DONE;
            end
            DONE: begin
               rd_q    <= rd_d;
               ct_o_q  <= ct_bit_s;
               tag_o_q <= tag_bit_s;
               rdy_q   <= 1'b1;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign cipher_textxSO      = ct_o_q;
   assign tagxSO              = tag_o_q;
   assign encryption_readyxSO = rdy_q;

endmodule

// File: tb/tb_ascon_aead.sv
// Directed bench for ascon_aead: two configurations (l=40/y=40 and l=0/y=64)
// run side by side against a table-driven Ascon-128 reference model.
module tb_ascon_aead;

   localparam int M = 128;
   localparam logic [127:0] KEY   = 128'h2db083053e848cefa30007336c47a5a1;
   localparam logic [127:0] NONCE = 128'h3f3607dbce3503ba84f5843d623de056;
   localparam logic [39:0]  AD_A  = 40'h4153434f4e;
   localparam logic [39:0]  PT_A  = 40'h6173636f6e;
   localparam logic [63:0]  PT_B  = 64'h6173636f6e2d3634;
   localparam logic [255:0] SBOX_TAB =
      256'h040b1f141a150902_1b0508121d03061c_1e13070e000d1118_100c0119160a0f17;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, start_s, r128_s, rpt_s;
   logic [2:0] key_s, nonce_s, ad_a_s, pt_a_s, ad_b_s, pt_b_s;
   logic [6:0] r64_s;
   logic       ct_a, tag_a, rdy_a, ct_b, tag_b, rdy_b;
   int         total = 0;
   int         bad = 0;
   logic [127:0] exp_ct_a, exp_tag_a, exp_ct_b, exp_tag_b;

   ascon_aead dut_a (
      .clk(clk), .rst(rst), .keyxSI(key_s), .noncexSI(nonce_s),
      .associated_dataxSI(ad_a_s), .plain_textxSI(pt_a_s),
      .encryption_startxSI(start_s), .r_64xSI(r64_s), .r_128xSI(r128_s), .r_ptxSI(rpt_s),
      .cipher_textxSO(ct_a), .tagxSO(tag_a), .encryption_readyxSO(rdy_a));

   ascon_aead #(.l(0), .y(64)) dut_b (
      .clk(clk), .rst(rst), .keyxSI(key_s), .noncexSI(nonce_s),
      .associated_dataxSI(ad_b_s), .plain_textxSI(pt_b_s),
      .encryption_startxSI(start_s), .r_64xSI(r64_s), .r_128xSI(r128_s), .r_ptxSI(rpt_s),
      .cipher_textxSO(ct_b), .tagxSO(tag_b), .encryption_readyxSO(rdy_b));

   task automatic check(input string name, input logic [159:0] got, input logic [159:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h, want %h", name, got, exp);
      end
   endtask

   function automatic logic [63:0] rot_m(input logic [63:0] v, input int p);
      logic [127:0] d;
      d = {v, v} >> p;
      return d[63:0];
   endfunction

   function automatic logic [319:0] perm_m(input logic [319:0] s_in, input int n);
      logic [63:0]  x [5];
      logic [63:0]  t [5];
      logic [255:0] tab;
      logic [4:0]   idx, o;
      int           j;
      tab = SBOX_TAB;
      for (int q = 0; q < 5; q++) x[q] = s_in[319 - 64*q -: 64];
      for (int i = 0; i < n; i++) begin
         j = 12 - n + i;
         x[2][7:0] = x[2][7:0] ^ 8'(((15 - j) << 4) | j);
         for (int bt = 0; bt < 64; bt++) begin
            idx = {x[0][bt], x[1][bt], x[2][bt], x[3][bt], x[4][bt]};
            o = tab[(31 - int'(idx))*8 +: 5];
            for (int q = 0; q < 5; q++) t[q][bt] = o[4-q];
         end
         x[0] = t[0] ^ rot_m(t[0], 19) ^ rot_m(t[0], 28);
         x[1] = t[1] ^ rot_m(t[1], 61) ^ rot_m(t[1], 39);
         x[2] = t[2] ^ rot_m(t[2], 1)  ^ rot_m(t[2], 6);
         x[3] = t[3] ^ rot_m(t[3], 10) ^ rot_m(t[3], 17);
         x[4] = t[4] ^ rot_m(t[4], 7)  ^ rot_m(t[4], 41);
      end
      return {x[0], x[1], x[2], x[3], x[4]};
   endfunction

   // Reference Ascon-128 encryption; ad/pt are right-aligned alen/plen-bit words.
   function automatic void model(input logic [127:0] key, input logic [127:0] nonce,
                                 input logic [127:0] ad, input int alen,
                                 input logic [127:0] pt, input int plen,
                                 output logic [127:0] ct, output logic [127:0] tag);
      logic [319:0] s;
      int pos;
      logic bv;
      s = {64'h80400c0600000000, key, nonce};
      s = perm_m(s, 12);
      s[127:0] = s[127:0] ^ key;
      if (alen > 0) begin
         for (int bi = 0; bi < alen/64 + 1; bi++) begin
            for (int t = 0; t < 64; t++) begin
               pos = bi*64 + t;
               if (pos < alen) bv = ad[alen-1-pos];
               else bv = (pos == alen);
               s[319-t] = s[319-t] ^ bv;
            end
            s = perm_m(s, 6);
         end
      end
      s[0] = s[0] ^ 1'b1;
      ct = '0;
      for (int bi = 0; bi < plen/64 + 1; bi++) begin
         for (int t = 0; t < 64; t++) begin
            pos = bi*64 + t;
            if (pos < plen) bv = pt[plen-1-pos];
            else bv = (pos == plen);
            s[319-t] = s[319-t] ^ bv;
            if (pos < plen) ct[plen-1-pos] = s[319-t];
         end
         if (bi < plen/64) s = perm_m(s, 6);
      end
      s[255:128] = s[255:128] ^ key;
      s = perm_m(s, 12);
      tag = s[127:0] ^ key;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic noise();
      key_s   = 3'($urandom);
      nonce_s = 3'($urandom);
      ad_a_s  = 3'($urandom);
      pt_a_s  = 3'($urandom);
      ad_b_s  = 3'($urandom);
      pt_b_s  = 3'($urandom);
      r64_s   = 7'($urandom);
      r128_s  = 1'($urandom);
      rpt_s   = 1'($urandom);
   endtask

   task automatic load();
      for (int i = 0; i < M; i++) begin
         noise();
         key_s[0]   = KEY[127-i];
         nonce_s[0] = NONCE[127-i];
         if (i < 40) begin
            ad_a_s[0] = AD_A[39-i];
            pt_a_s[0] = PT_A[39-i];
         end
         if (i < 64) pt_b_s[0] = PT_B[63-i];
         tick();
      end
   endtask

   task automatic run(input string name, input int hold, input bit poke);
      int lat_a, lat_b, cnt, j;
      logic [M+3:0] oct_a, otag_a, oct_b, otag_b, ect_a, etag_a, ect_b, etag_b;
      logic held_a, held_b;
      lat_a = -1;
      lat_b = -1;
      noise();
      start_s = 1'b1;
      tick();
      cnt = 0;
      while ((lat_a < 0 || lat_b < 0) && cnt < 200) begin
         if (cnt >= hold - 1) start_s = 1'b0;
         noise();
         tick();
         cnt++;
         if (rdy_a && lat_a < 0) lat_a = cnt;
         if (rdy_b && lat_b < 0) lat_b = cnt;
      end
      check({name, ":latency_a"}, 160'(lat_a), 160'(36));
      check({name, ":latency_b"}, 160'(lat_b), 160'(36));
      held_a = 1'b1;
      held_b = 1'b1;
      for (int n = 0; n < M + 4; n++) begin
         j = (n <= 2) ? 0 : n - 2;
         if (j > M - 1) j = M - 1;
         ect_a[n]  = (j < 40) ? exp_ct_a[j] : 1'b0;
         ect_b[n]  = (j < 64) ? exp_ct_b[j] : 1'b0;
         etag_a[n] = exp_tag_a[j];
         etag_b[n] = exp_tag_b[j];
         oct_a[n]  = ct_a;
         otag_a[n] = tag_a;
         oct_b[n]  = ct_b;
         otag_b[n] = tag_b;
         held_a    = held_a & rdy_a;
         held_b    = held_b & rdy_b;
         start_s   = poke && (n >= 10) && (n < 20);
         noise();
         tick();
      end
      start_s = 1'b0;
      check({name, ":ct_a"},    160'(oct_a),  160'(ect_a));
      check({name, ":tag_a"},   160'(otag_a), 160'(etag_a));
      check({name, ":ct_b"},    160'(oct_b),  160'(ect_b));
      check({name, ":tag_b"},   160'(otag_b), 160'(etag_b));
      check({name, ":ready_a"}, 160'(held_a), 160'(1));
      check({name, ":ready_b"}, 160'(held_b), 160'(1));
   endtask

   initial begin
      logic [5:0] acc;
      rst = 1'b1;
      start_s = 1'b0;
      noise();
      model(KEY, NONCE, 128'(AD_A), 40, 128'(PT_A), 40, exp_ct_a, exp_tag_a);
      model(KEY, NONCE, 128'h0, 0, 128'(PT_B), 64, exp_ct_b, exp_tag_b);
      tick();
      tick();
      check("reset_a", 160'({ct_a, tag_a, rdy_a}), 160'(0));
      check("reset_b", 160'({ct_b, tag_b, rdy_b}), 160'(0));
      rst = 1'b0;

      load();
      run("run1", 1, 1'b0);

      // Same vector, fresh randomness, long start pulse and a start poke during readout.
      rst = 1'b1;
      tick();
      check("abort_readout", 160'({ct_a, tag_a, rdy_a, ct_b, tag_b, rdy_b}), 160'(0));
      rst = 1'b0;
      load();
      run("run2", 3, 1'b1);

      // Reset in the middle of initialization must leave the core quiet.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      load();
      noise();
      start_s = 1'b1;
      tick();
      start_s = 1'b0;
      repeat (5) begin
         noise();
         tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      acc = '0;
      repeat (60) begin
         acc = acc | {ct_a, tag_a, rdy_a, ct_b, tag_b, rdy_b};
         noise();
         tick();
      end
      check("abort_init", 160'(acc), 160'(0));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      load();
      run("run3", 1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
